// File: rtl/mole_scheduler.sv
`default_nettype none
// ============================================================================
// Module      : mole_scheduler
// Description : Whack-a-mole game sequencer. Enables the shared tick counter
//               while a game runs, times each round as a no-mole gap followed
//               by one lit mole, picks positions from a free-running LFSR,
//               and tallies hits and misses until N_ROUNDS rounds are done.
// Ports       : clk         system clock
//               rst         asynchronous reset, active-high
//               i_start     single-cycle start pulse (honoured in IDLE/DONE)
//               i_tick      tick from the tick counter (may stick while gated)
//               i_btn       single-cycle button pulses, one bit per position
//               o_tick_en   enable to the tick counter
//               o_mole      one-hot lit mole, zero when none is lit
//               o_score     hits this game (saturating)
//               o_misses    timeouts this game (saturating)
//               o_busy      game in progress (GAP or SHOW)
//               o_game_over high in DONE
// Revision    : 1.0 - initial release
// ============================================================================
module mole_scheduler #(
  parameter int         N_MOLES   = 4,
  parameter int         GAP_TICKS = 30,
  parameter int         ON_TICKS  = 80,
  parameter int         N_ROUNDS  = 20,
  parameter int         SCORE_W   = 8,
  parameter logic [7:0] LFSR_SEED = 8'hA5
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               i_start,
  input  logic               i_tick,
  input  logic [N_MOLES-1:0] i_btn,
  output logic               o_tick_en,
  output logic [N_MOLES-1:0] o_mole,
  output logic [SCORE_W-1:0] o_score,
  output logic [SCORE_W-1:0] o_misses,
  output logic               o_busy,
  output logic               o_game_over
);

  localparam int c_MAX_T = (GAP_TICKS > ON_TICKS) ? GAP_TICKS : ON_TICKS;
  localparam int c_CNT_W = (c_MAX_T > 1) ? $clog2(c_MAX_T) : 1;
  localparam int c_RND_W = (N_ROUNDS > 1) ? $clog2(N_ROUNDS) : 1;
  localparam int c_POS_W = (N_MOLES > 1) ? $clog2(N_MOLES) : 1;

  localparam logic [c_CNT_W-1:0] c_GAP_LAST = c_CNT_W'(GAP_TICKS - 1);
  localparam logic [c_CNT_W-1:0] c_ON_LAST  = c_CNT_W'(ON_TICKS - 1);
  localparam logic [c_RND_W-1:0] c_RND_LAST = c_RND_W'(N_ROUNDS - 1);
  localparam logic [c_POS_W-1:0] c_POS_LAST = c_POS_W'(N_MOLES - 1);

  localparam logic [1:0] c_IDLE = 2'd0;
  localparam logic [1:0] c_GAP  = 2'd1;
  localparam logic [1:0] c_SHOW = 2'd2;
  localparam logic [1:0] c_DONE = 2'd3;

  logic [1:0]         r_state;
  logic [1:0]         w_state_nxt;
  logic [7:0]         r_lfsr;
  logic               r_tick_en;
  logic               r_tick_en_q;
  logic [c_CNT_W-1:0] r_tick_cnt;
  logic [c_RND_W-1:0] r_round;
  logic [N_MOLES-1:0] r_mole;
  logic [SCORE_W-1:0] r_score;
  logic [SCORE_W-1:0] r_misses;
  logic               r_busy;
  logic               r_game_over;
  logic [c_POS_W-1:0] r_prev_pos;
  logic               r_prev_vld;

  logic               w_tick_vld;
  logic               w_gap_end;
  logic               w_hit;
  logic               w_tmo;
  logic               w_round_end;
  logic               w_last;
  logic               w_lfsr_fb;
  logic [c_POS_W-1:0] w_pos_raw;
  logic [c_POS_W-1:0] w_pos;
  logic [N_MOLES-1:0] w_mole_hot;

  logic [c_CNT_W-1:0] w_tick_cnt_nxt;
  logic [c_RND_W-1:0] w_round_nxt;
  logic [N_MOLES-1:0] w_mole_nxt;
  logic [SCORE_W-1:0] w_score_nxt;
  logic [SCORE_W-1:0] w_misses_nxt;
  logic               w_tick_en_nxt;
  logic               w_busy_nxt;
  logic               w_game_over_nxt;
  logic [c_POS_W-1:0] w_prev_pos_nxt;
  logic               w_prev_vld_nxt;

  // A tick only counts once the counter has been enabled for a full cycle,
  // so a tick level left high while gated off is not mistaken for a pulse.
  assign w_tick_vld  = i_tick & r_tick_en_q;
  assign w_gap_end   = (r_state == c_GAP) && w_tick_vld && (r_tick_cnt == c_GAP_LAST);
  assign w_hit       = (r_state == c_SHOW) && (|(i_btn & r_mole));
  assign w_tmo       = (r_state == c_SHOW) && w_tick_vld && (r_tick_cnt == c_ON_LAST) && !w_hit;
  assign w_round_end = w_hit | w_tmo;
  assign w_last      = (r_round == c_RND_LAST);

  // Fibonacci LFSR, taps 8,6,5,4; maximal length so it never hits zero.
  assign w_lfsr_fb = r_lfsr[7] ^ r_lfsr[5] ^ r_lfsr[4] ^ r_lfsr[3];

  // Position from the LFSR; bump by one when it would repeat last round.
  assign w_pos_raw = c_POS_W'(r_lfsr % 8'(N_MOLES));
  always_comb begin
    w_pos = w_pos_raw;
    if (r_prev_vld && (w_pos_raw == r_prev_pos)) begin
      w_pos = (w_pos_raw == c_POS_LAST) ? '0 : w_pos_raw + 1'b1;
    end
  end
  assign w_mole_hot = N_MOLES'(1) << w_pos;

  // FSM: state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= c_IDLE;
    else     r_state <= w_state_nxt;
  end

  // FSM: next-state logic
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      c_IDLE, c_DONE: if (i_start)     w_state_nxt = c_GAP;
      c_GAP:          if (w_gap_end)   w_state_nxt = c_SHOW;
      c_SHOW:         if (w_round_end) w_state_nxt = w_last ? c_DONE : c_GAP;
      default:                         w_state_nxt = c_IDLE;
    endcase
  end

  // FSM: output / datapath next values (all registered below)
  always_comb begin
    w_tick_cnt_nxt  = r_tick_cnt;
    w_round_nxt     = r_round;
    w_mole_nxt      = '0;
    w_score_nxt     = r_score;
    w_misses_nxt    = r_misses;
    w_prev_pos_nxt  = r_prev_pos;
    w_prev_vld_nxt  = r_prev_vld;
    w_tick_en_nxt   = (w_state_nxt == c_GAP) || (w_state_nxt == c_SHOW);
    w_busy_nxt      = w_tick_en_nxt;
    w_game_over_nxt = (w_state_nxt == c_DONE);

    if (w_state_nxt != r_state) begin
      w_tick_cnt_nxt = '0;
    end else if (w_tick_vld && ((r_state == c_GAP) || (r_state == c_SHOW))) begin
      w_tick_cnt_nxt = r_tick_cnt + 1'b1;
    end

    case (r_state)
      c_IDLE, c_DONE: begin
        if (i_start) begin
          w_score_nxt    = '0;
          w_misses_nxt   = '0;
          w_round_nxt    = '0;
          w_prev_vld_nxt = 1'b0;
        end
      end
      c_GAP: begin
        if (w_gap_end) begin
          w_mole_nxt     = w_mole_hot;
          w_prev_pos_nxt = w_pos;
          w_prev_vld_nxt = 1'b1;
        end
      end
      c_SHOW: begin
        w_mole_nxt = r_mole;
        if (w_hit) begin
          w_mole_nxt  = '0;
          w_score_nxt = (r_score == '1) ? r_score : r_score + 1'b1;
        end else if (w_tmo) begin
          w_mole_nxt   = '0;
          w_misses_nxt = (r_misses == '1) ? r_misses : r_misses + 1'b1;
        end
        if (w_round_end && !w_last) w_round_nxt = r_round + 1'b1;
      end
      default: w_mole_nxt = '0;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_lfsr      <= LFSR_SEED;
      r_tick_en   <= 1'b0;
      r_tick_en_q <= 1'b0;
      r_tick_cnt  <= '0;
      r_round     <= '0;
      r_mole      <= '0;
      r_score     <= '0;
      r_misses    <= '0;
      r_busy      <= 1'b0;
      r_game_over <= 1'b0;
      r_prev_pos  <= '0;
      r_prev_vld  <= 1'b0;
    end else begin
      r_lfsr      <= {r_lfsr[6:0], w_lfsr_fb};
      r_tick_en   <= w_tick_en_nxt;
      r_tick_en_q <= r_tick_en;
      r_tick_cnt  <= w_tick_cnt_nxt;
      r_round     <= w_round_nxt;
      r_mole      <= w_mole_nxt;
      r_score     <= w_score_nxt;
      r_misses    <= w_misses_nxt;
      r_busy      <= w_busy_nxt;
      r_game_over <= w_game_over_nxt;
      r_prev_pos  <= w_prev_pos_nxt;
      r_prev_vld  <= w_prev_vld_nxt;
    end
  end

  assign o_tick_en   = r_tick_en;
  assign o_mole      = r_mole;
  assign o_score     = r_score;
  assign o_misses    = r_misses;
  assign o_busy      = r_busy;
  assign o_game_over = r_game_over;

endmodule
`default_nettype wire

// File: tb/tb_mole_scheduler.sv
`default_nettype none
// ============================================================================
// Module      : tb_mole_scheduler
// Description : Self-checking bench for mole_scheduler. Plays whole games
//               with directed and randomized button behaviour and compares
//               mole timing, positions, score and misses with a round-level
//               reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mole_scheduler;

  localparam int NM  = 4;
  localparam int GAP = 2;
  localparam int ON  = 3;
  localparam int NR  = 3;
  localparam int SW  = 8;

  logic          clk = 1'b0;
  logic          rst;
  logic          i_start;
  logic          i_tick;
  logic [NM-1:0] i_btn;
  logic          o_tick_en;
  logic [NM-1:0] o_mole;
  logic [SW-1:0] o_score;
  logic [SW-1:0] o_misses;
  logic          o_busy;
  logic          o_game_over;

  int   n_checks = 0;
  int   n_errors = 0;
  int   vt_cnt   = 0;   // ticks the DUT should have accepted so far
  logic en_prev;
  logic [7:0] m_lfsr;
  logic [7:0] m_lfsr_used;
  logic hold = 1'b0;
  int   phase = 0;
  int   m_score;
  int   m_miss;

  mole_scheduler #(
    .N_MOLES  (NM),
    .GAP_TICKS(GAP),
    .ON_TICKS (ON),
    .N_ROUNDS (NR),
    .SCORE_W  (SW),
    .LFSR_SEED(8'hA5)
  ) u_dut (
    .clk        (clk),
    .rst        (rst),
    .i_start    (i_start),
    .i_tick     (i_tick),
    .i_btn      (i_btn),
    .o_tick_en  (o_tick_en),
    .o_mole     (o_mole),
    .o_score    (o_score),
    .o_misses   (o_misses),
    .o_busy     (o_busy),
    .o_game_over(o_game_over)
  );

  always #5 clk = ~clk;

  // Tick source: one pulse every 5 clocks, or stuck high while hold is set.
  initial begin
    i_tick = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      phase  = (phase == 4) ? 0 : phase + 1;
      i_tick = hold || (phase == 0);
    end
  end

  // Reference: the LFSR value used at each edge, and the count of ticks that
  // arrive while the enable has been high for at least one prior cycle.
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      en_prev     <= 1'b0;
      m_lfsr      <= 8'hA5;
      m_lfsr_used <= 8'hA5;
    end else begin
      if (i_tick && en_prev) vt_cnt <= vt_cnt + 1;
      en_prev     <= o_tick_en;
      m_lfsr_used <= m_lfsr;
      m_lfsr      <= {m_lfsr[6:0], m_lfsr[7] ^ m_lfsr[5] ^ m_lfsr[4] ^ m_lfsr[3]};
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: observed %0d, expected %0d (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // mode: -1 random per round, 0 no press, 1 correct press, 2 wrong presses,
  //       3 correct press on the timeout tick.
  task automatic play_game(input int mode, input bit noise, input int rst_round, input bit chk_first);
    int base, sb, cyc, act, dly, pos, prev_pos;
    logic [NM-1:0] exp_mole, b;
    bit seen, hit, tmo;
    @(posedge clk); #2; i_start = 1'b1;
    @(posedge clk); #2; i_start = 1'b0;
    check("start_busy", o_busy, 1);
    check("start_tick_en", o_tick_en, 1);
    check("start_score", o_score, 0);
    check("start_misses", o_misses, 0);
    check("start_game_over", o_game_over, 0);
    m_score = 0; m_miss = 0; cyc = 0; prev_pos = 0;
    for (int r = 0; r < NR; r++) begin
      base = vt_cnt;
      seen = 1'b0;
      for (int w = 0; w < 200 && !seen; w++) begin
        if (o_mole != '0) seen = 1'b1;
        else begin
          i_btn   = noise ? NM'($urandom) : '0;
          i_start = noise && ($urandom_range(0, 7) == 0);
          @(posedge clk); #2; cyc++;
        end
      end
      i_btn = '0; i_start = 1'b0;
      if (!seen) begin
        check("mole_rise_timeout", 32'(seen), 1);
        return;
      end
      check("gap_ticks", vt_cnt - base, GAP);
      if (chk_first && r == 0) check("first_rise_cycles", cyc, 3);
      pos = m_lfsr_used % NM;
      if (r > 0 && pos == prev_pos) pos = (pos + 1) % NM;
      exp_mole = NM'(1) << pos;
      check("mole_pos", o_mole, exp_mole);
      if (r > 0) check("mole_repeat", 32'(o_mole == (NM'(1) << prev_pos)), 0);
      prev_pos = pos;

      if (r == rst_round) begin
        #1; rst = 1'b1; #1;
        check("rst_mole", o_mole, 0);
        check("rst_score", o_score, 0);
        check("rst_misses", o_misses, 0);
        check("rst_tick_en", o_tick_en, 0);
        check("rst_busy", o_busy, 0);
        check("rst_game_over", o_game_over, 0);
        @(posedge clk); #2; rst = 1'b0;
        repeat (3) @(posedge clk);
        #2;
        check("rst_idle_tick_en", o_tick_en, 0);
        check("rst_idle_busy", o_busy, 0);
        return;
      end

      sb  = vt_cnt;
      act = (mode < 0) ? int'($urandom_range(0, 3)) : mode;
      dly = (mode < 0) ? int'($urandom_range(0, 14)) : 0;
      hit = 1'b0; tmo = 1'b0;
      for (int k = 0; k < 50 && !(hit || tmo); k++) begin
        b = '0;
        case (act)
          1: if (k == dly) b = exp_mole;
          2: if ($urandom_range(0, 1) == 1) b = NM'($urandom) & ~exp_mole;
          3: if (i_tick && (vt_cnt - sb) == ON - 1) b = exp_mole;
          default: b = '0;
        endcase
        i_btn = b;
        hit = (b & exp_mole) != '0;
        tmo = !hit && i_tick && ((vt_cnt - sb) == ON - 1);
        @(posedge clk); #2;
        i_btn = '0;
        if (hit) m_score = (m_score < 255) ? m_score + 1 : 255;
        else if (tmo) m_miss = (m_miss < 255) ? m_miss + 1 : 255;
        if (hit || tmo) check("mole_clear", o_mole, 0);
        else            check("mole_hold", o_mole, exp_mole);
      end
      check("score", o_score, m_score);
      check("misses", o_misses, m_miss);
    end
    check("end_game_over", o_game_over, 1);
    check("end_busy", o_busy, 0);
    check("end_tick_en", o_tick_en, 0);
    check("end_mole", o_mole, 0);
  endtask

  initial begin
    rst = 1'b1; i_start = 1'b0; i_btn = '0;
    repeat (3) @(posedge clk);
    #2;
    check("reset_mole", o_mole, 0);
    check("reset_score", o_score, 0);
    check("reset_misses", o_misses, 0);
    check("reset_tick_en", o_tick_en, 0);
    check("reset_busy", o_busy, 0);
    check("reset_game_over", o_game_over, 0);
    rst = 1'b0;
    repeat (2) @(posedge clk);

    play_game(0, 1'b0, -1, 1'b0);          // no presses: all misses
    check("all_miss_count", o_misses, NR);
    check("all_miss_score", o_score, 0);
    play_game(1, 1'b0, -1, 1'b0);          // press 1 clk after rise
    check("all_hit_score", o_score, NR);
    check("all_hit_misses", o_misses, 0);
    play_game(2, 1'b0, -1, 1'b0);          // wrong buttons only
    check("wrong_btn_score", o_score, 0);
    play_game(3, 1'b0, -1, 1'b0);          // hit on the timeout tick
    check("tie_score", o_score, NR);
    check("tie_misses", o_misses, 0);
    play_game(1, 1'b0, 1, 1'b0);           // reset during second SHOW

    hold = 1'b1;                           // stuck tick while gated off
    repeat (4) @(posedge clk);
    play_game(0, 1'b0, -1, 1'b1);
    hold = 1'b0;

    for (int g = 0; g < 50; g++) play_game(-1, 1'b1, -1, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire
